demux_stream_sched: RTL and testbench

Clocked scheduler that generalises the team's 1:2 demux into an N-way stream distributor with valid/ready handshakes. A single input stream is routed to one of N output lanes. In addressed mode the sender picks the lane with a dest field. In round-robin mode the block load-balances across lanes and skips any lane that cannot take a word. Each lane has a 1-entry holding register, and the block counts words it drops because of invalid destinations.

---
 rtl/demux_stream_sched.sv | 131 +++++++++++++
 tb/tb_demux_stream_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_sched.sv
// N-way stream distributor with valid/ready handshakes.
// One input stream feeds N lanes, each with a 1-entry holding register.
// Addressed mode routes by in_dest. Round-robin mode load-balances and skips
// lanes that cannot take a word. Words sent to a nonexistent lane are
// swallowed and counted.
module demux_stream_sched #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SELW  = 2,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_dest,
  input  logic                 in_mode,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 err,
  output logic [CNTW-1:0]      drop_cnt
);

  localparam int PTRW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]            lane_valid;
  logic [N-1:0][WIDTH-1:0] lane_data;
  logic [PTRW-1:0]         ptr;

  logic [N-1:0]    free;
  logic            dest_ok;
  logic            dest_free;
  logic            rr_found;
  logic [PTRW-1:0] rr_idx;
  logic [PTRW-1:0] ptr_next;
  logic            accept;
  logic            drop;
  logic [N-1:0]    load;

  // (base + k) mod N without a divider; k is always < N here.
  function automatic logic [PTRW-1:0] wrap_idx(input logic [PTRW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N) j = j - N;
    return PTRW'(j);
  endfunction

  // A lane can take a word if it is empty or is being drained this cycle.
  assign free = ~lane_valid | out_ready;

  // Addressed-mode decode; one-hot compare keeps the index in range for any SELW.
  always_comb begin
    dest_ok   = 1'b0;
    dest_free = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_dest == SELW'(i)) begin
        dest_ok   = 1'b1;
        dest_free = free[i];
      end
    end
  end

  // Round-robin scan: first free lane starting at ptr, wrapping modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && free[wrap_idx(ptr, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_idx(ptr, k);
      end
    end
    ptr_next = wrap_idx(rr_idx, 1);
  end

  // Handshake and target selection; in_ready never looks at in_valid.
  always_comb begin
    if (rst)          in_ready = 1'b0;
    else if (in_mode) in_ready = rr_found;
    else              in_ready = dest_ok ? dest_free : 1'b1;
    accept = in_valid && in_ready;
    drop   = accept && !in_mode && !dest_ok;
    load   = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && !drop) begin
        if (in_mode) load[i] = (rr_idx == PTRW'(i));
        else         load[i] = (in_dest == SELW'(i));
      end
    end
  end

  // Lane holding registers: refill wins over drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid <= '0;
      lane_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          lane_valid[i] <= 1'b1;
          lane_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer only moves on a round-robin accept.
  always_ff @(posedge clk) begin
    if (rst)                   ptr <= '0;
    else if (accept && in_mode) ptr <= ptr_next;
  end

  // Drop reporting: one err pulse per dropped word, saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err <= drop;
      if (drop && drop_cnt != {CNTW{1'b1}}) drop_cnt <= drop_cnt + CNTW'(1);
    end
  end

  assign out_valid = lane_valid;
  assign out_data  = lane_data;

endmodule

// File: tb/tb_demux_stream_sched.sv
// Directed bench for demux_stream_sched (WIDTH=8, N=3, SELW=2, CNTW=8).
module tb_demux_stream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_mode;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [23:0] out_data;
  logic        err;
  logic [7:0]  drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  demux_stream_sched #(.WIDTH(8), .N(3), .SELW(2), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lane(input int i);
    return out_data[i*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_mode = 1'b1; out_ready = 3'b111;
    in_dest = 2'd0; in_data = 8'h00;
    step();
    step();
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 000", out_valid); end
    tests_run++;
    if (err !== 1'b0 || drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_err_cnt: got err=%b cnt=%0d want 0/0", err, drop_cnt); end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_addressed();
    int bad;
    in_mode = 1'b0; in_dest = 2'd1; in_data = 8'hA5; out_ready = 3'b000; in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL addr_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b010 || lane(1) !== 8'hA5) begin
      tests_failed++; $display("FAIL addr_route: got valid=%b lane1=%h want 010/a5", out_valid, lane(1));
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_valid !== 3'b010 || lane(1) !== 8'hA5) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL addr_hold: got %0d bad idle cycles want 0", bad); end
    out_ready = 3'b111;
    step();
    tests_run++;
    if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL addr_drain: got %b want 000", out_valid); end
  endtask

  task automatic test_rr_rotation();
    logic [2:0] exp_v;
    in_mode = 1'b1; out_ready = 3'b111;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 1); in_valid = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rr_ready_%0d: got %b want 1", i, in_ready); end
      step();
      exp_v = 3'b001 << (i % 3);
      tests_run++;
      if (out_valid !== exp_v || lane(i % 3) !== 8'(i + 1)) begin
        tests_failed++;
        $display("FAIL rr_lane_%0d: got valid=%b data=%h want %b/%h", i, out_valid, lane(i % 3), exp_v, 8'(i + 1));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_rr_skip();
    int bad;
    // ptr should be back at 0: this word must land in lane0, leaving ptr=1
    in_mode = 1'b1; out_ready = 3'b111; in_data = 8'h0F; in_valid = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 3'b001 || lane(0) !== 8'h0F) begin
      tests_failed++; $display("FAIL rr_ptr_wrap: got valid=%b lane0=%h want 001/0f", out_valid, lane(0));
    end
    in_mode = 1'b0; in_dest = 2'd1; in_data = 8'h20; out_ready = 3'b101;
    step();
    in_mode = 1'b1; in_data = 8'h10;
    step();
    tests_run++;
    if (out_valid !== 3'b110 || lane(2) !== 8'h10) begin
      tests_failed++; $display("FAIL rr_skip_a: got valid=%b lane2=%h want 110/10", out_valid, lane(2));
    end
    in_data = 8'h11;
    step();
    tests_run++;
    if (out_valid !== 3'b011 || lane(0) !== 8'h11) begin
      tests_failed++; $display("FAIL rr_skip_b: got valid=%b lane0=%h want 011/11", out_valid, lane(0));
    end
    out_ready = 3'b000; in_mode = 1'b0; in_dest = 2'd2; in_data = 8'h12;
    step();
    in_mode = 1'b1; in_data = 8'hEE;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rr_full_ready: got %b want 0", in_ready); end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (out_valid !== 3'b111 || lane(0) !== 8'h11 || lane(1) !== 8'h20 || lane(2) !== 8'h12) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL rr_full_hold: got %0d bad cycles want 0", bad); end
    // ptr must still be 1: next word goes to lane1
    out_ready = 3'b111; in_data = 8'h13;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b010 || lane(1) !== 8'h13) begin
      tests_failed++; $display("FAIL rr_ptr_hold: got valid=%b lane1=%h want 010/13", out_valid, lane(1));
    end
    step();
  endtask

  task automatic test_back_to_back_refill();
    in_mode = 1'b0; in_dest = 2'd0; in_data = 8'h33; out_ready = 3'b000; in_valid = 1'b1;
    step();
    in_data = 8'h44;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    step();
    tests_run++;
    if (out_valid !== 3'b001 || lane(0) !== 8'h33) begin
      tests_failed++; $display("FAIL bp_hold: got valid=%b lane0=%h want 001/33", out_valid, lane(0));
    end
    out_ready = 3'b001;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_high: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b001 || lane(0) !== 8'h44) begin
      tests_failed++; $display("FAIL bp_refill: got valid=%b lane0=%h want 001/44", out_valid, lane(0));
    end
    step();
    tests_run++;
    if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL bp_drain: got %b want 000", out_valid); end
  endtask

  task automatic test_invalid_dest();
    int bad_err;
    int bad_cnt;
    int exp_cnt;
    in_mode = 1'b0; in_dest = 2'd3; in_data = 8'h99; out_ready = 3'b000; in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL drop_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1 || drop_cnt !== 8'd1 || out_valid !== 3'b000) begin
      tests_failed++; $display("FAIL drop_first: got err=%b cnt=%0d valid=%b want 1/1/000", err, drop_cnt, out_valid);
    end
    step();
    tests_run++;
    if (err !== 1'b0 || drop_cnt !== 8'd1) begin
      tests_failed++; $display("FAIL drop_pulse_end: got err=%b cnt=%0d want 0/1", err, drop_cnt);
    end
    in_valid = 1'b1;
    bad_err = 0; bad_cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_cnt = (1 + i > 255) ? 255 : 1 + i;
      if (err !== 1'b1) bad_err++;
      if (drop_cnt !== 8'(exp_cnt)) bad_cnt++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (bad_err != 0) begin tests_failed++; $display("FAIL drop_burst_err: got %0d missing pulses want 0", bad_err); end
    tests_run++;
    if (bad_cnt != 0 || drop_cnt !== 8'd255) begin
      tests_failed++; $display("FAIL drop_saturate: got cnt=%0d bad=%0d want 255/0", drop_cnt, bad_cnt);
    end
    step();
    tests_run++;
    if (err !== 1'b0 || drop_cnt !== 8'd255 || out_valid !== 3'b000) begin
      tests_failed++; $display("FAIL drop_after: got err=%b cnt=%0d valid=%b want 0/255/000", err, drop_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    // ptr is 2 here (last round-robin word went to lane1)
    in_mode = 1'b0; out_ready = 3'b000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_dest = 2'(i); in_data = 8'(8'hC0 + i);
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b111) begin tests_failed++; $display("FAIL mid_fill: got %b want 111", out_valid); end
    rst = 1'b1; in_mode = 1'b1; out_ready = 3'b111; in_valid = 1'b1; in_data = 8'h77;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    step();
    tests_run++;
    if (out_valid !== 3'b000 || err !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL mid_rst_state: got valid=%b err=%b cnt=%0d want 000/0/0", out_valid, err, drop_cnt);
    end
    rst = 1'b0; out_ready = 3'b000; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b001 || lane(0) !== 8'h55) begin
      tests_failed++; $display("FAIL mid_first_rr: got valid=%b lane0=%h want 001/55", out_valid, lane(0));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; in_mode = 1'b0; out_ready = 3'b000;
    test_reset();
    test_addressed();
    test_rr_rotation();
    test_rr_skip();
    test_back_to_back_refill();
    test_invalid_dest();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
